// File: rtl/mem_arbiter_if.sv
// Fetch/data request ports and the single-port memory bus of the RiSC-16 memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus memory side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port memory with data priority,
// starvation-forced fetch grants and one-cycle read return routing.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              rd_pend;
    logic              rd_owner;
    logic              force_i;
    logic              i_gnt;
    logic              d_gnt;
    logic              mem_en;
    logic              mem_we;
    logic              i_rvalid;
    logic              d_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        force_i   = bus.i_req && (starve_cnt == StarveMax);
        // Grants are gated by reset so every combinational output is quiet while held.
        d_gnt     = reset && bus.d_req && !force_i;
        i_gnt     = reset && bus.i_req && !(bus.d_req && !force_i);
        mem_en    = i_gnt || d_gnt;
        mem_we    = d_gnt && bus.d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (i_gnt) begin
            mem_addr = bus.i_addr;
        end else if (d_gnt) begin
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
        end
        if (!bus.i_req || i_gnt) begin
            starve_nxt = '0;
        end else if (starve_cnt < StarveMax) begin
            starve_nxt = starve_cnt + 4'd1;
        end else begin
            starve_nxt = starve_cnt;
        end
        i_rvalid = rd_pend && !rd_owner;
        d_rvalid = rd_pend && rd_owner;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            rd_pend    <= mem_en && !mem_we;
            rd_owner   <= d_gnt;
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_rvalid  = i_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.i_rdata   = i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle reference model of the grant/return rules
// plus hand-computed literal checks on the main scenarios.
module tb_mem_arbiter;
    localparam int Limit = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(Limit)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int a);
        return 16'(16'hA000 ^ (a * 257));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environment: one-cycle read latency, writes take effect at the edge.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] = bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    // Reference model: who wins this cycle, and what read is owed to whom now.
    logic [15:0] mram [256];
    int          m_starve = 0;
    bit          m_pv = 1'b0;
    bit          m_po = 1'b0;
    logic [15:0] m_pd = '0;
    bit          e_gi, e_gd;
    logic [15:0] e_addr, e_wd;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_gnt", 32'({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}), 32'd0);
            chk("rst_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
            chk("rst_rv", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
            chk("rst_rd", 32'({bus.i_rdata, bus.d_rdata}), 32'd0);
            chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
            m_starve = 0;
            m_pv     = 1'b0;
        end else begin
            e_gi   = bus.i_req && (m_starve >= Limit || !bus.d_req);
            e_gd   = bus.d_req && !e_gi;
            e_addr = e_gi ? bus.i_addr : (e_gd ? bus.d_addr : 16'h0);
            e_wd   = e_gd ? bus.d_wdata : 16'h0;
            chk("i_gnt", 32'(bus.i_gnt), 32'(e_gi));
            chk("d_gnt", 32'(bus.d_gnt), 32'(e_gd));
            chk("mem_en", 32'(bus.mem_en), 32'(e_gi || e_gd));
            chk("mem_we", 32'(bus.mem_we), 32'(e_gd && bus.d_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
            chk("i_rvalid", 32'(bus.i_rvalid), 32'(m_pv && !m_po));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_pv && m_po));
            chk("i_rdata", 32'(bus.i_rdata), 32'((m_pv && !m_po) ? m_pd : 16'h0));
            chk("d_rdata", 32'(bus.d_rdata), 32'((m_pv && m_po) ? m_pd : 16'h0));
            chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
            m_pv = (e_gi || e_gd) && !(e_gd && bus.d_we);
            m_po = e_gd;
            m_pd = mram[e_addr[7:0]];
            if (e_gd && bus.d_we) mram[bus.d_addr[7:0]] = bus.d_wdata;
            if (bus.i_req && !e_gi) m_starve = (m_starve + 1 > Limit) ? Limit : m_starve + 1;
            else                    m_starve = 0;
        end
    end

    task automatic drive(input bit ir, input logic [15:0] ia, input bit dr, input bit we,
                         input logic [15:0] da, input logic [15:0] wd);
        @(posedge clk);
        #1;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = wd;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    logic [11:0] gseq;
    bit          any_i;

    initial begin
        for (int a = 0; a < 256; a++) begin
            ram[a]  = init_word(a);
            mram[a] = init_word(a);
        end
        ram[3] = 16'h1234;  mram[3] = 16'h1234;
        ram[4] = 16'h5678;  mram[4] = 16'h5678;
        ram[32] = 16'hCAFE; mram[32] = 16'hCAFE;
        bus.i_req = 1'b1; bus.i_addr = 16'h0007;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0008; bus.d_wdata = 16'h1111;
        bus.mem_rdata = '0;

        // Requests held during reset must see nothing.
        at_neg();
        at_neg();
        chk("lit_rst_en", 32'(bus.mem_en), 32'd0);

        // Fetch only, first cycle after reset release.
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0003; bus.d_req = 1'b0; bus.d_we = 1'b0;
        at_neg();
        chk("lit_fetch_gnt", 32'(bus.i_gnt), 32'd1);
        chk("lit_fetch_addr", 32'(bus.mem_addr), 32'h0003);
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("lit_fetch_rv", 32'({bus.i_rvalid, bus.d_rvalid}), 32'b10);
        chk("lit_fetch_rd", 32'(bus.i_rdata), 32'h1234);

        // Store, then read it back.
        drive(0, 0, 1, 1, 16'h0010, 16'hBEEF);
        at_neg();
        chk("lit_store_bus", 32'({bus.mem_en, bus.mem_we}), 32'b11);
        chk("lit_store_addr", 32'(bus.mem_addr), 32'h0010);
        chk("lit_store_wd", 32'(bus.mem_wdata), 32'hBEEF);
        drive(0, 0, 1, 0, 16'h0010, 16'h0);
        at_neg();
        chk("lit_store_norv", 32'({bus.i_rvalid, bus.d_rvalid}), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("lit_load_rd", 32'(bus.d_rdata), 32'hBEEF);

        // Continuous contention: fetch wins every fifth cycle.
        for (int k = 0; k < 12; k++) begin
            drive(1, 16'h0004, 1, 0, 16'h0020, 16'h0);
            at_neg();
            gseq[k] = bus.i_gnt;
        end
        chk("lit_contention", 32'(gseq), 32'h210);

        // Alternating owners back to back.
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 16'h0020, 16'h0);
        at_neg();
        chk("lit_alt_dgnt", 32'(bus.d_gnt), 32'd1);
        drive(1, 16'h0004, 0, 0, 0, 0);
        at_neg();
        chk("lit_alt_d", 32'({bus.d_rvalid, bus.i_rvalid, bus.i_gnt}), 32'b101);
        chk("lit_alt_drd", 32'(bus.d_rdata), 32'hCAFE);
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("lit_alt_i", 32'({bus.i_rvalid, bus.d_rvalid}), 32'b10);
        chk("lit_alt_ird", 32'(bus.i_rdata), 32'h5678);

        // Fetch withdrawn under contention.
        any_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k < 2, 16'h0005, 1, 0, 16'h0030, 16'h0);
            at_neg();
            any_i |= bus.i_gnt;
        end
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        chk("lit_withdraw_gnt", 32'(any_i), 32'd0);
        chk("lit_withdraw_cnt", 32'(dut.starve_cnt), 32'd0);

        // Reset pulled with a fetch read in flight.
        drive(1, 16'h0006, 0, 0, 0, 0);
        at_neg();
        chk("lit_rstrd_gnt", 32'(bus.i_gnt), 32'd1);
        #2;
        reset = 1'b0;
        bus.i_req = 1'b0;
        at_neg();
        chk("lit_rstrd_rv", 32'(bus.i_rvalid), 32'd0);
        at_neg();
        @(posedge clk);
        #1;
        reset = 1'b1;
        at_neg();
        chk("lit_rstrd_after", 32'({bus.i_rvalid, bus.d_rvalid, bus.mem_en}), 32'd0);
        chk("lit_rstrd_cnt", 32'(dut.starve_cnt), 32'd0);

        // Mixed traffic, model-checked every cycle.
        for (int k = 0; k < 24; k++) begin
            drive((k % 3) != 0, 16'(k + 64), (k % 2) == 0, (k % 4) == 0, 16'(k + 96),
                  16'(k * 16'h0111));
        end
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        at_neg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory word-address width.
REQ-002 Parameter DATA_W, default 16, memory word width (RiSC-16 word).
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  fetch port request; held with i_addr stable until granted.
REQ-007 i_addr  input  ADDR_W  fetch read address.
REQ-008 i_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 i_rvalid  output  1  fetch read data valid (registered).
REQ-010 i_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data port request; held with d_we/d_addr/d_wdata stable until granted.
REQ-012 d_we  input  1  data access is a store (1) or load (0).
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle (combinational).
REQ-016 d_rvalid  output  1  load data valid (registered).
REQ-017 d_rdata  output  DATA_W  load data.
REQ-018 mem_en, mem_we  output  1 each  single-port memory enable and write enable.
REQ-019 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address/write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid the cycle after a read enable.

Function
REQ-021 At most one of i_gnt/d_gnt SHALL be high per cycle; mem_en = i_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata come from the granted port, 0 when idle.
REQ-022 Priority: if i_req and starve_cnt == STARVE_LIMIT, grant fetch; else if d_req, grant data; else if i_req, grant fetch; else no grant.
REQ-023 starve_cnt (4-bit register): +1 when i_req & !i_gnt, saturating at STARVE_LIMIT; cleared to 0 when i_gnt or !i_req.
REQ-024 Read latency exactly 1: a granted read in cycle N SHALL produce rvalid for its owner, and only its owner, in cycle N+1; stores produce no rvalid.
REQ-025 Pending-read state: registers rd_pend (1 bit) and rd_owner (0=fetch, 1=data) loaded every cycle from the current grant; rvalid outputs are decoded from them.
REQ-026 i_rdata = mem_rdata when i_rvalid, else 0; d_rdata = mem_rdata when d_rvalid, else 0.
REQ-027 Throughput: one grant per cycle with no bubbles; back-to-back reads from alternating owners SHALL each return on their own port.
REQ-028 Simultaneous i_req and d_req with starve_cnt < STARVE_LIMIT: data wins, fetch waits, counter increments.
REQ-029 A request deasserted before grant is dropped without side effect (no memory access, counter cleared if it was fetch).

Reset
REQ-030 While reset is low: i_gnt, d_gnt, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; i_rvalid, d_rvalid = 0; i_rdata, d_rdata = 0; starve_cnt = 0; rd_pend = 0.
REQ-031 Reset asserted with a read in flight SHALL discard it; no rvalid appears after reset deasserts.
REQ-032 First grant possible in the first rising edge cycle after reset goes high.

Verification
REQ-033 Fetch only: i_req=1, i_addr=0x0003, mem returns 0x1234 -> i_gnt same cycle, i_rvalid=1 and i_rdata=0x1234 next cycle, d_rvalid=0.
REQ-034 Store: d_req=1, d_we=1, d_addr=0x0010, d_wdata=0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF for one cycle; no rvalid next cycle.
REQ-035 Contention: i_req and d_req held 1 continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I...; i_gnt every 5th cycle.
REQ-036 Alternating reads: D load 0x0020 cycle N, I fetch 0x0004 cycle N+1 -> d_rvalid at N+1, i_rvalid at N+2, each with its own mem_rdata.
REQ-037 Reset mid-read: grant fetch read, pull reset low before next edge -> i_rvalid stays 0, all outputs 0, starve_cnt 0 after release.
REQ-038 Request withdrawn: i_req high 2 cycles under d_req contention then low -> no fetch access, starve_cnt returns to 0.
